// File: rtl/mips_pkg.sv
// Shared defaults for the MIPS core datapath: data/index widths and the
// hard-wired zero register index.
package mips_pkg;
  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int ZERO_REG   = 0;
endpackage

// File: rtl/regfile_2r1w.sv
// Two-read, one-write register file with asynchronous clear and a
// hard-wired zero entry; reads are raw array contents (no bypass).
module regfile_2r1w
  import mips_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr_a,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b
);
  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else if (we && waddr != ADDR_W'(ZERO_REG)) begin
      regs[waddr] <= wdata;
    end
  end

  // Entry 0 is masked on read so its storage contents never matter.
  assign rdata_a = (raddr_a == ADDR_W'(ZERO_REG)) ? '0 : regs[raddr_a];
  assign rdata_b = (raddr_b == ADDR_W'(ZERO_REG)) ? '0 : regs[raddr_b];
endmodule

// File: rtl/mem_wb_writeback.sv
// MEM/WB consumer: writeback select, register-file commit with
// write-before-read bypass to the ID read ports, and a saturating retire counter.
module mem_wb_writeback
  import mips_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              reg_write,
  input  logic              mem_to_reg,
  input  logic [DATA_W-1:0] read_data,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [ADDR_W-1:0] write_reg,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  output logic [DATA_W-1:0] wb_data,
  output logic              wb_valid,
  output logic [CNT_W-1:0]  retire_count
);
  logic [DATA_W-1:0] rf_a;
  logic [DATA_W-1:0] rf_b;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  assign wb_data  = mem_to_reg ? read_data : alu_result;
  assign wb_valid = reg_write && (write_reg != ADDR_W'(ZERO_REG));

  regfile_2r1w #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_regfile (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (wb_valid),
    .waddr   (write_reg),
    .wdata   (wb_data),
    .raddr_a (rs_addr),
    .raddr_b (rt_addr),
    .rdata_a (rf_a),
    .rdata_b (rf_b)
  );

  // wb_valid already excludes index 0, so a bypass hit can never shadow $0.
  always_comb begin
    rs_data = rf_a;
    rt_data = rf_b;
    if (wb_valid && rs_addr == write_reg) rs_data = wb_data;
    if (wb_valid && rt_addr == write_reg) rt_data = wb_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retire_count <= '0;
    end else if (wb_valid) begin
      retire_count <= sat_inc(retire_count);
    end
  end
endmodule

// File: tb/tb_mem_wb_writeback.sv
// Directed and randomized bench for mem_wb_writeback against an
// array-based register-file model; counter width reduced to reach saturation.
module tb_mem_wb_writeback;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int CNT_W  = 4;
  localparam int CNT_MAX = 15;

  logic              clk;
  logic              rst_n;
  logic              reg_write;
  logic              mem_to_reg;
  logic [DATA_W-1:0] read_data;
  logic [DATA_W-1:0] alu_result;
  logic [ADDR_W-1:0] write_reg;
  logic [ADDR_W-1:0] rs_addr;
  logic [ADDR_W-1:0] rt_addr;
  logic [DATA_W-1:0] rs_data;
  logic [DATA_W-1:0] rt_data;
  logic [DATA_W-1:0] wb_data;
  logic              wb_valid;
  logic [CNT_W-1:0]  retire_count;

  int checks = 0;
  int errors = 0;

  logic [31:0] mregs [32];
  int          mcnt;

  mem_wb_writeback #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .CNT_W  (CNT_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .reg_write    (reg_write),
    .mem_to_reg   (mem_to_reg),
    .read_data    (read_data),
    .alu_result   (alu_result),
    .write_reg    (write_reg),
    .rs_addr      (rs_addr),
    .rt_addr      (rt_addr),
    .rs_data      (rs_data),
    .rt_data      (rt_data),
    .wb_data      (wb_data),
    .wb_valid     (wb_valid),
    .retire_count (retire_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  function automatic logic [31:0] m_wb();
    return mem_to_reg ? read_data : alu_result;
  endfunction

  function automatic logic m_valid();
    return reg_write && (write_reg != 0);
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    if (a == 0) return 32'h0;
    if (m_valid() && a == write_reg) return m_wb();
    return mregs[a];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic rw, input logic mtr, input logic [31:0] rd,
                       input logic [31:0] alu, input logic [4:0] wr,
                       input logic [4:0] rs, input logic [4:0] rt);
    reg_write  = rw;
    mem_to_reg = mtr;
    read_data  = rd;
    alu_result = alu;
    write_reg  = wr;
    rs_addr    = rs;
    rt_addr    = rt;
    #1;
  endtask

  task automatic check_comb(input string tag);
    check({tag, ".wb_data"},  wb_data, m_wb());
    check({tag, ".wb_valid"}, {31'b0, wb_valid}, {31'b0, m_valid()});
    check({tag, ".rs_data"},  rs_data, m_read(rs_addr));
    check({tag, ".rt_data"},  rt_data, m_read(rt_addr));
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    if (rst_n && m_valid()) begin
      mregs[write_reg] = m_wb();
      if (mcnt < CNT_MAX) mcnt++;
    end
    #1;
    check({tag, ".retire_count"}, {28'b0, retire_count}, mcnt);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) mregs[i] = 32'h0;
    mcnt = 0;
  endtask

  initial begin
    model_reset();
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    #1;
    check("reset.retire_count", {28'b0, retire_count}, 32'h0);
    for (int i = 0; i < 32; i++) begin
      drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'(i), 5'(31 - i));
      check("reset.rs_zero", rs_data, 32'h0);
      check("reset.rt_zero", rt_data, 32'h0);
    end

    // ALU path commit
    drive(1'b1, 1'b0, 32'h0, 32'h0000_1234, 5'd8, 5'd1, 5'd2);
    check_comb("alu");
    tick("alu");
    drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd8, 5'd8);
    check("alu.rs8", rs_data, 32'h0000_1234);
    check("alu.count1", {28'b0, retire_count}, 32'd1);

    // load path with same-cycle bypass on both ports
    drive(1'b1, 1'b1, 32'hDEAD_BEEF, 32'h1111_1111, 5'd9, 5'd9, 5'd9);
    check("load.rs_bypass", rs_data, 32'hDEAD_BEEF);
    check("load.rt_bypass", rt_data, 32'hDEAD_BEEF);
    check_comb("load");
    tick("load");
    drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd9, 5'd9);
    check("load.rs_after", rs_data, 32'hDEAD_BEEF);
    check("load.rt_after", rt_data, 32'hDEAD_BEEF);

    // $0 protection
    drive(1'b1, 1'b0, 32'h0, 32'hFFFF_FFFF, 5'd0, 5'd0, 5'd0);
    check("zero.wb_valid", {31'b0, wb_valid}, 32'h0);
    check("zero.rs", rs_data, 32'h0);
    tick("zero");
    check("zero.count", {28'b0, retire_count}, 32'd2);
    drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0);
    check("zero.rs_after", rs_data, 32'h0);

    // reg_write=0: no write, no bypass
    drive(1'b0, 1'b0, 32'h0, 32'h5555_5555, 5'd8, 5'd8, 5'd8);
    check("nowr.rs", rs_data, 32'h0000_1234);
    check_comb("nowr");
    tick("nowr");
    check("nowr.rs_after", rs_data, 32'h0000_1234);

    // randomized traffic
    for (int n = 0; n < 200; n++) begin
      logic [4:0] wr;
      logic [4:0] rs;
      logic [4:0] rt;
      wr = 5'($urandom_range(0, 31));
      rs = ($urandom_range(0, 3) == 0) ? wr : 5'($urandom_range(0, 31));
      rt = ($urandom_range(0, 3) == 0) ? wr : 5'($urandom_range(0, 31));
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, $urandom, wr, rs, rt);
      check_comb("rand");
      tick("rand");
    end

    // saturation from a clean counter
    rst_n = 1'b0;
    model_reset();
    #1 rst_n = 1'b1;
    for (int n = 0; n < 20; n++) begin
      drive(1'b1, 1'b0, 32'h0, $urandom, 5'($urandom_range(1, 31)), 5'd0, 5'd0);
      tick("sat");
    end
    check("sat.final", {28'b0, retire_count}, 32'd15);

    // asynchronous reset mid-cycle
    drive(1'b1, 1'b0, 32'h0, 32'hA5A5_0001, 5'd8, 5'd0, 5'd0);
    tick("pre_async");
    drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd8, 5'd8);
    check("pre_async.rs8", rs_data, 32'hA5A5_0001);
    #1 rst_n = 1'b0;
    model_reset();
    #1;
    check("async.rs8", rs_data, 32'h0);
    check("async.count", {28'b0, retire_count}, 32'h0);

    // valid writeback during reset is lost; bypass stays combinational
    drive(1'b1, 1'b1, 32'hCAFE_F00D, 32'h0, 5'd10, 5'd10, 5'd3);
    check("inrst.rs_bypass", rs_data, 32'hCAFE_F00D);
    check_comb("inrst");
    tick("inrst");
    rst_n = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd10, 5'd10);
    check("inrst.lost", rs_data, 32'h0);
    drive(1'b1, 1'b0, 32'h0, 32'h0BAD_CAFE, 5'd11, 5'd11, 5'd0);
    tick("post_rst");
    check("post_rst.count", {28'b0, retire_count}, 32'd1);
    drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd11, 5'd10);
    check("post_rst.rs11", rs_data, 32'h0BAD_CAFE);
    check("post_rst.rt10", rt_data, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_wb_writeback.md
Name: mem_wb_writeback

Overview:
- Consumer end of the MEM/WB pipeline interface: selects the writeback value, commits it to the 32-entry register file, and serves the two ID-stage read ports.
- Internal write-before-read bypass, so no separate WB→ID forwarding path is needed.
- Saturating retire counter for bring-up and performance visibility.
- Sits between the MEM/WB register outputs and the ID stage of the 5-stage pipelined MIPS core.

Parameters:
- DATA_W, 32, register and writeback data width.
- ADDR_W, 5, register index width (2**ADDR_W entries).
- CNT_W, 16, retire counter width.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- reg_write  in  1  RegWrite from the MEM/WB register.
- mem_to_reg  in  1  MemtoReg from MEM/WB: 1 selects read_data, 0 selects alu_result.
- read_data  in  DATA_W  load data from MEM/WB.
- alu_result  in  DATA_W  ALU result from MEM/WB.
- write_reg  in  ADDR_W  destination register from MEM/WB.
- rs_addr  in  ADDR_W  ID-stage read port A index.
- rt_addr  in  ADDR_W  ID-stage read port B index.
- rs_data  out  DATA_W  read port A data.
- rt_data  out  DATA_W  read port B data.
- wb_data  out  DATA_W  selected writeback value, exported for the EX forwarding mux.
- wb_valid  out  1  high when reg_write=1 and write_reg≠0.
- retire_count  out  CNT_W  number of committed register writes, saturating.

Behaviour:
- Reset: rst_n low asynchronously clears all register-file entries and retire_count to 0 and holds them there. Register-file contents and the counter are the only state.
- Combinational outputs during reset: wb_data and wb_valid stay combinational functions of the inputs. rs_data and rt_data read back 0 unless bypassed.
- Writeback select: wb_data = mem_to_reg ? read_data : alu_result. Pure combinational, zero latency.
- Commit: at posedge clk with rst_n high and wb_valid=1, regs[write_reg] <= wb_data. The write is visible to the array the next cycle.
- Register $0: writes to index 0 are discarded. Any read of index 0 returns 0 regardless of array contents or bypass.
- Read ports: combinational, asynchronous, 0-cycle latency.
- Bypass: if wb_valid=1 and rs_addr==write_reg, rs_data = wb_data, otherwise regs[rs_addr]. Same rule for rt_data and rt_addr.
- Both ports may read the same index, including the index being written; both see the bypassed value.
- reg_write=0: no array change and no bypass, regardless of write_reg or mem_to_reg.
- Retire counter: at posedge, if wb_valid=1 and retire_count < 2**CNT_W-1, increment by 1. At the maximum it holds (no wrap).
- Reset mid-stream: rst_n asserted in the same cycle as a valid writeback means the write is lost and the register reads 0 after the edge. Release is synchronous in effect: the first commit occurs at the first posedge after rst_n rises.
- X-safety: a write_reg outside the valid range cannot occur (full decode of ADDR_W). No latch inference.

Decomposition:
- Shared package (mips_pkg): DATA_W and ADDR_W defaults, ZERO_REG = 0.
- One sub-module is natural: regfile_2r1w (array, async reset clear, $0 masking, write port), with bypass and select logic kept in the top.
- The retire counter stays in the top.

Test Plan:
- Reset → release rst_n, read every index on both ports → all 0, retire_count=0.
- Commit ALU path: reg_write=1, mem_to_reg=0, alu_result=0x0000_1234, write_reg=8, one edge → rs_addr=8 gives 0x0000_1234, retire_count=1.
- Commit load path with same-cycle bypass: mem_to_reg=1, read_data=0xDEAD_BEEF, write_reg=9, rs_addr=rt_addr=9 before the edge → both ports show 0xDEAD_BEEF combinationally and after the edge.
- $0 protection: reg_write=1, write_reg=0, alu_result=0xFFFF_FFFF → wb_valid=0, rs_addr=0 reads 0, retire_count unchanged.
- reg_write=0 with write_reg=8, alu_result=0x5555_5555 → rs_addr=8 still returns the prior 0x0000_1234, no bypass.
- Saturation and async reset: CNT_W=4, issue 20 valid writes → retire_count=15. Assert rst_n mid-cycle → regs and counter read 0 immediately, without waiting for a clock edge.
